// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: optional x1..x31 clear sequence after reset,
// then round-robin arbitration of ALU (A) and load (B) writebacks into one write port.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | clearing x1..x31 with INIT_VAL, one write per edge, no grants
// RUN   | arbitrating A/B writeback requests, one grant per cycle
module regfile_wb_arbiter #(
    parameter bit          INIT_EN  = 1'b1,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        we,
    output logic [4:0]  rd_a,
    output logic [31:0] rd_dt,
    output logic        init_done
);

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic       state;
    logic [4:0] init_cnt;
    logic       prio;
    logic       run_ok;
    logic       grant_a;
    logic       grant_b;

    // Readies are also held low while reset is asserted, even when INIT_EN=0
    // leaves the FSM sitting in RUN during reset.
    assign run_ok    = (state == ST_RUN) && rest;
    assign grant_a   = run_ok && a_valid && (!b_valid || !prio);
    assign grant_b   = run_ok && b_valid && (!a_valid || prio);
    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign init_done = (state == ST_RUN);

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state    <= INIT_EN ? ST_INIT : ST_RUN;
            init_cnt <= 5'd1;
            prio     <= 1'b0;
            we       <= 1'b0;
            rd_a     <= 5'd0;
            rd_dt    <= 32'h0;
        end else begin
            case (state)
                ST_INIT: begin
                    we       <= 1'b1;
                    rd_a     <= init_cnt;
                    rd_dt    <= INIT_VAL;
                    init_cnt <= init_cnt + 5'd1;
                    if (init_cnt == 5'd31) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    if (grant_a) begin
                        we    <= (a_rd != 5'd0);
                        rd_a  <= a_rd;
                        rd_dt <= a_data;
                    end else if (grant_b) begin
                        we    <= (b_rd != 5'd0);
                        rd_a  <= b_rd;
                        rd_dt <= b_data;
                    end else begin
                        we <= 1'b0;
                    end
                    // Contention hands the next tie to whoever lost this one.
                    if (a_valid && b_valid) begin
                        prio <= !prio;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: reset/clear sequence, directed
// arbitration vectors, and randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rest;
    logic        a_valid, b_valid;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, we, init_done;
    logic [4:0]  rd_a;
    logic [31:0] rd_dt;

    logic        rest0;
    logic        d0_a_valid, d0_b_valid;
    logic [4:0]  d0_a_rd, d0_b_rd;
    logic [31:0] d0_a_data, d0_b_data;
    logic        d0_a_ready, d0_b_ready, d0_we, d0_init_done;
    logic [4:0]  d0_rd_a;
    logic [31:0] d0_rd_dt;

    regfile_wb_arbiter #(.INIT_EN(1'b1), .INIT_VAL(32'hDEADBEEF)) dut (
        .clk(clk), .rest(rest),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .we(we), .rd_a(rd_a), .rd_dt(rd_dt), .init_done(init_done)
    );

    regfile_wb_arbiter #(.INIT_EN(1'b0), .INIT_VAL(32'h0)) dut0 (
        .clk(clk), .rest(rest0),
        .a_valid(d0_a_valid), .a_rd(d0_a_rd), .a_data(d0_a_data), .a_ready(d0_a_ready),
        .b_valid(d0_b_valid), .b_rd(d0_b_rd), .b_data(d0_b_data), .b_ready(d0_b_ready),
        .we(d0_we), .rd_a(d0_rd_a), .rd_dt(d0_rd_dt), .init_done(d0_init_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bd;
        logic        era;
        logic        erb;
        logic        ewe;
        logic [4:0]  erd;
        logic [31:0] edt;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad,
                                logic bv, logic [4:0] brd, logic [31:0] bd,
                                logic era, logic erb, logic ewe,
                                logic [4:0] erd, logic [31:0] edt);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad;
        v.bv = bv; v.brd = brd; v.bd = bd;
        v.era = era; v.erb = erb; v.ewe = ewe; v.erd = erd; v.edt = edt;
        return v;
    endfunction

    // Clear sequence for n edges; requests are held valid to prove they are ignored.
    task automatic init_seq(input int n);
        for (int i = 1; i <= n; i++) begin
            #2;
            chk("init_a_ready", 32'(a_ready), 32'd0);
            chk("init_b_ready", 32'(b_ready), 32'd0);
            chk("init_done_low", 32'(init_done), 32'd0);
            @(posedge clk); #1;
            chk("init_we", 32'(we), 32'd1);
            chk("init_rd_a", 32'(rd_a), 32'(i));
            chk("init_rd_dt", rd_dt, 32'hDEADBEEF);
        end
    endtask

    // Behavioural model state for the randomized phase
    logic        m_prio;
    logic [4:0]  m_rd;
    logic [31:0] m_dt;
    logic        m_we;
    logic        a_pend, b_pend;
    int          winner;

    initial begin
        rest = 1'b0; rest0 = 1'b0;
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h1234;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h5678;
        d0_a_valid = 1'b1; d0_a_rd = 5'd4; d0_a_data = 32'hCAFE0004;
        d0_b_valid = 1'b0; d0_b_rd = 5'd0; d0_b_data = 32'h0;

        tbl[0]  = mk(1, 5'd5, 32'h11, 1, 5'd6, 32'h22, 1, 0, 1, 5'd5, 32'h11);
        tbl[1]  = mk(1, 5'd5, 32'h11, 1, 5'd6, 32'h22, 0, 1, 1, 5'd6, 32'h22);
        tbl[2]  = mk(1, 5'd5, 32'h11, 1, 5'd6, 32'h22, 1, 0, 1, 5'd5, 32'h11);
        tbl[3]  = mk(1, 5'd5, 32'h11, 1, 5'd6, 32'h22, 0, 1, 1, 5'd6, 32'h22);
        tbl[4]  = mk(0, 5'd0, 32'h0, 1, 5'd7, 32'h33, 0, 1, 1, 5'd7, 32'h33);
        tbl[5]  = mk(0, 5'd0, 32'h0, 1, 5'd7, 32'h33, 0, 1, 1, 5'd7, 32'h33);
        tbl[6]  = mk(0, 5'd0, 32'h0, 1, 5'd7, 32'h33, 0, 1, 1, 5'd7, 32'h33);
        tbl[7]  = mk(1, 5'd8, 32'h44, 1, 5'd7, 32'h33, 1, 0, 1, 5'd8, 32'h44);
        tbl[8]  = mk(1, 5'd8, 32'h44, 1, 5'd7, 32'h33, 0, 1, 1, 5'd7, 32'h33);
        tbl[9]  = mk(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 1, 0, 0, 5'd0, 32'hFFFFFFFF);
        tbl[10] = mk(1, 5'd9, 32'h55, 1, 5'd10, 32'h66, 1, 0, 1, 5'd9, 32'h55);
        tbl[11] = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd9, 32'h55);
        tbl[12] = mk(1, 5'd1, 32'h1, 1, 5'd0, 32'h77, 0, 1, 0, 5'd0, 32'h77);
        tbl[13] = mk(1, 5'd2, 32'h2, 1, 5'd3, 32'h3, 1, 0, 1, 5'd2, 32'h2);

        // Held in reset: check the asynchronous reset values of both instances
        @(negedge clk);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_rd_a", 32'(rd_a), 32'd0);
        chk("rst_rd_dt", rd_dt, 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_d0_init_done", 32'(d0_init_done), 32'd1);
        chk("rst_d0_a_ready", 32'(d0_a_ready), 32'd0);

        // INIT_EN=0 instance: grant straight after release, write on the next edge
        rest0 = 1'b1;
        #1;
        chk("d0_a_ready", 32'(d0_a_ready), 32'd1);
        @(posedge clk); #1;
        chk("d0_we", 32'(d0_we), 32'd1);
        chk("d0_rd_a", 32'(d0_rd_a), 32'd4);
        chk("d0_rd_dt", d0_rd_dt, 32'hCAFE0004);
        chk("d0_init_done", 32'(d0_init_done), 32'd1);
        d0_a_valid = 1'b0;

        // Clear sequence interrupted at counter=17, then restarted from x1
        @(negedge clk);
        rest = 1'b1;
        init_seq(16);
        rest = 1'b0;
        #1;
        chk("abort_we", 32'(we), 32'd0);
        chk("abort_init_done", 32'(init_done), 32'd0);
        repeat (2) @(negedge clk);
        rest = 1'b1;
        init_seq(31);
        chk("init_done_high", 32'(init_done), 32'd1);

        for (int i = 0; i < 14; i++) begin
            a_valid = tbl[i].av; a_rd = tbl[i].ard; a_data = tbl[i].ad;
            b_valid = tbl[i].bv; b_rd = tbl[i].brd; b_data = tbl[i].bd;
            #2;
            chk($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(tbl[i].era));
            chk($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].erb));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_we", i), 32'(we), 32'(tbl[i].ewe));
            chk($sformatf("vec%0d_rd_a", i), 32'(rd_a), 32'(tbl[i].erd));
            chk($sformatf("vec%0d_rd_dt", i), rd_dt, tbl[i].edt);
        end

        // Randomized traffic; a losing requester keeps its request until granted
        m_prio = 1'b1; m_rd = 5'd2; m_dt = 32'h2;
        a_pend = 1'b0; b_pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!a_pend) begin
                a_valid = 1'($urandom_range(0, 1));
                a_rd    = 5'($urandom);
                a_data  = $urandom;
            end
            if (!b_pend) begin
                b_valid = 1'($urandom_range(0, 1));
                b_rd    = 5'($urandom);
                b_data  = $urandom;
            end
            if (a_valid && b_valid) begin
                winner = m_prio ? 1 : 0;
                m_prio = (winner == 0);
            end else if (a_valid) begin
                winner = 0;
            end else if (b_valid) begin
                winner = 1;
            end else begin
                winner = -1;
            end
            m_we = 1'b0;
            if (winner == 0) begin
                m_rd = a_rd; m_dt = a_data; m_we = (a_rd != 5'd0);
            end else if (winner == 1) begin
                m_rd = b_rd; m_dt = b_data; m_we = (b_rd != 5'd0);
            end
            #2;
            chk("rnd_a_ready", 32'(a_ready), 32'(winner == 0));
            chk("rnd_b_ready", 32'(b_ready), 32'(winner == 1));
            @(posedge clk); #1;
            chk("rnd_we", 32'(we), 32'(m_we));
            chk("rnd_rd_a", 32'(rd_a), 32'(m_rd));
            chk("rnd_rd_dt", rd_dt, m_dt);
            a_pend = a_valid && (winner != 0);
            b_pend = b_valid && (winner != 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
